ysyx_22050078_mc_ctrl: RTL and testbench

//  Multi-cycle sequencer for the npc core; successor to the single-cycle top.

---
 rtl/ysyx_22050078_mc_ctrl_if.sv | 29 ++
 rtl/ysyx_22050078_mc_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ysyx_22050078_mc_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050078_mc_ctrl_if.sv
// Fetch and LSU valid/ready handshake bundle between the multi-cycle sequencer
// (master) and the bus ports (slave).
interface ysyx_22050078_mc_ctrl_if #(
   parameter int PC_WIDTH   = 64,
   parameter int INST_WIDTH = 32
);
   logic                  if_req_valid;
   logic                  if_req_ready;
   logic [PC_WIDTH-1:0]   if_req_addr;
   logic                  if_rsp_valid;
   logic [INST_WIDTH-1:0] if_rsp_inst;
   logic                  if_rsp_err;
   logic                  lsu_req_valid;
   logic                  lsu_req_ready;
   logic                  lsu_rsp_valid;
   logic                  lsu_rsp_err;

   modport master (
      output if_req_valid, if_req_addr, lsu_req_valid,
      input  if_req_ready, if_rsp_valid, if_rsp_inst, if_rsp_err,
      input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_err
   );

   modport slave (
      input  if_req_valid, if_req_addr, lsu_req_valid,
      output if_req_ready, if_rsp_valid, if_rsp_inst, if_rsp_err,
      output lsu_req_ready, lsu_rsp_valid, lsu_rsp_err
   );
endinterface

// File: rtl/ysyx_22050078_mc_ctrl.sv
// Multi-cycle sequencer for the npc core: owns PC/IR, runs the fetch and LSU
// handshakes, gates the regfile write and flags ebreak halt, bus errors and timeouts.
module ysyx_22050078_mc_ctrl #(
   parameter int                  PC_WIDTH   = 64,
   parameter int                  INST_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(64'h0000_0000_8000_0000),
   parameter int                  TIMEOUT    = 255,
   parameter int                  CNT_WIDTH  = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   ysyx_22050078_mc_ctrl_if.master bus,
   output logic [PC_WIDTH-1:0]     pc,
   output logic [INST_WIDTH-1:0]   inst,
   input  logic                    exu_is_mem,
   input  logic                    exu_redirect,
   input  logic [PC_WIDTH-1:0]     exu_next_pc,
   input  logic                    exu_rd_wen,
   input  logic [63:0]             a0_value,
   output logic                    rd_wen,
   output logic                    retire,
   output logic                    halted,
   output logic                    halt_good,
   output logic                    error,
   output logic [CNT_WIDTH-1:0]    cycle_cnt,
   output logic [CNT_WIDTH-1:0]    instret_cnt
);
   localparam int                    WAIT_WIDTH = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_WIDTH-1:0] WAIT_LAST  = WAIT_WIDTH'(TIMEOUT);
   localparam logic [INST_WIDTH-1:0] EBREAK     = INST_WIDTH'(32'h0010_0073);

   typedef enum logic [2:0] {
      F_REQ  = 3'd0,
      F_WAIT = 3'd1,
      EXEC   = 3'd2,
      M_REQ  = 3'd3,
      M_WAIT = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6,
      ERROR  = 3'd7
   } state_t;

   state_t                state_r;
   logic [PC_WIDTH-1:0]   pc_r;
   logic [INST_WIDTH-1:0] inst_r;
   logic [WAIT_WIDTH-1:0] wait_cnt_r;
   logic                  if_req_valid_r;
   logic                  lsu_req_valid_r;
   logic                  halted_r;
   logic                  halt_good_r;
   logic                  error_r;
   logic [CNT_WIDTH-1:0]  cycle_cnt_r;
   logic [CNT_WIDTH-1:0]  instret_cnt_r;
   logic                  misalign_s;
   logic                  rd_wen_s;
   logic                  retire_s;

   // Retire and write-enable decode; the redirect alignment check only matters in WB
   always_comb begin
      misalign_s = 1'b0;
      rd_wen_s   = 1'b0;
      retire_s   = 1'b0;
      case (state_r)
         WB: begin
            misalign_s = exu_redirect && (exu_next_pc[1:0] != 2'b00);
            rd_wen_s   = exu_rd_wen && !misalign_s;
            retire_s   = !misalign_s;
         end
         EXEC: begin
            retire_s = (inst_r == EBREAK);
         end
         default: begin
            retire_s = 1'b0;
         end
      endcase
   end

   // Sequencer state, PC/IR, handshake valids, sticky flags and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= F_REQ;
         pc_r            <= RESET_PC;
         inst_r          <= '0;
         wait_cnt_r      <= '0;
         if_req_valid_r  <= 1'b0;
         lsu_req_valid_r <= 1'b0;
         halted_r        <= 1'b0;
         halt_good_r     <= 1'b0;
         error_r         <= 1'b0;
         cycle_cnt_r     <= '0;
         instret_cnt_r   <= '0;
      end else begin
         if ((state_r != HALT) && (state_r != ERROR)) begin
            cycle_cnt_r <= cycle_cnt_r + CNT_WIDTH'(1);
         end
         if (retire_s) begin
            instret_cnt_r <= instret_cnt_r + CNT_WIDTH'(1);
         end
         case (state_r)
            F_REQ: begin
               // valid comes up one cycle after reset so it is always a registered level
               if (!if_req_valid_r) begin
                  if_req_valid_r <= 1'b1;
               end else if (bus.if_req_ready) begin
                  if_req_valid_r <= 1'b0;
                  wait_cnt_r     <= '0;
                  state_r        <= F_WAIT;
               end
            end
            F_WAIT: begin
               if (bus.if_rsp_valid) begin
                  if (bus.if_rsp_err) begin
                     error_r <= 1'b1;
                     state_r <= ERROR;
                  end else begin
                     inst_r  <= bus.if_rsp_inst;
                     state_r <= EXEC;
                  end
               end else if (wait_cnt_r == WAIT_LAST) begin
                  error_r <= 1'b1;
                  state_r <= ERROR;
               end else begin
                  wait_cnt_r <= wait_cnt_r + WAIT_WIDTH'(1);
               end
            end
            EXEC: begin
               if (inst_r == EBREAK) begin
                  halted_r    <= 1'b1;
                  halt_good_r <= (a0_value == 64'd0);
                  state_r     <= HALT;
               end else if (exu_is_mem) begin
                  lsu_req_valid_r <= 1'b1;
                  state_r         <= M_REQ;
               end else begin
                  state_r <= WB;
               end
            end
            M_REQ: begin
               if (bus.lsu_req_ready) begin
                  lsu_req_valid_r <= 1'b0;
                  wait_cnt_r      <= '0;
                  state_r         <= M_WAIT;
               end
            end
            M_WAIT: begin
               if (bus.lsu_rsp_valid) begin
                  if (bus.lsu_rsp_err) begin
                     error_r <= 1'b1;
                     state_r <= ERROR;
                  end else begin
                     state_r <= WB;
                  end
               end else if (wait_cnt_r == WAIT_LAST) begin
                  error_r <= 1'b1;
                  state_r <= ERROR;
               end else begin
                  wait_cnt_r <= wait_cnt_r + WAIT_WIDTH'(1);
               end
            end
            WB: begin
               if (misalign_s) begin
                  error_r <= 1'b1;
                  state_r <= ERROR;
               end else begin
                  pc_r           <= exu_redirect ? exu_next_pc : (pc_r + PC_WIDTH'(32'd4));
                  if_req_valid_r <= 1'b1;
                  state_r        <= F_REQ;
               end
            end
            HALT: begin
               state_r <= HALT;
            end
            ERROR: begin
               state_r <= ERROR;
            end
            default: begin
               error_r <= 1'b1;
               state_r <= ERROR;
            end
         endcase
      end
   end

   assign bus.if_req_valid  = if_req_valid_r;
   assign bus.if_req_addr   = pc_r;
   assign bus.lsu_req_valid = lsu_req_valid_r;
   assign pc                = pc_r;
   assign inst              = inst_r;
   assign rd_wen            = rd_wen_s;
   assign retire            = retire_s;
   assign halted            = halted_r;
   assign halt_good         = halt_good_r;
   assign error             = error_r;
   assign cycle_cnt         = cycle_cnt_r;
   assign instret_cnt       = instret_cnt_r;
endmodule

// File: tb/tb_ysyx_22050078_mc_ctrl.sv
// Bench for ysyx_22050078_mc_ctrl: a task-driven bus responder with a scoreboard
// queue of expected fetch addresses plus a bench-side retire/cycle model.
module tb_ysyx_22050078_mc_ctrl;
   localparam int          TIMEOUT  = 255;
   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] ADDI     = 32'h0010_0093;
   localparam logic [31:0] LOAD     = 32'h0000_3083;
   localparam logic [31:0] STORE    = 32'h0010_3023;
   localparam logic [31:0] JAL      = 32'h1000_006f;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc;
   logic [31:0] inst;
   logic        exu_is_mem;
   logic        exu_redirect;
   logic [63:0] exu_next_pc;
   logic        exu_rd_wen;
   logic [63:0] a0_value;
   logic        rd_wen;
   logic        retire;
   logic        halted;
   logic        halt_good;
   logic        error;
   logic [63:0] cycle_cnt;
   logic [63:0] instret_cnt;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] addr_q[$];
   logic [63:0] exp_instret;
   logic [63:0] cyc;
   logic [63:0] last_cyc;
   logic        have_last;

   ysyx_22050078_mc_ctrl_if #(.PC_WIDTH(64), .INST_WIDTH(32)) bus ();

   ysyx_22050078_mc_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .pc           (pc),
      .inst         (inst),
      .exu_is_mem   (exu_is_mem),
      .exu_redirect (exu_redirect),
      .exu_next_pc  (exu_next_pc),
      .exu_rd_wen   (exu_rd_wen),
      .a0_value     (a0_value),
      .rd_wen       (rd_wen),
      .retire       (retire),
      .halted       (halted),
      .halt_good    (halt_good),
      .error        (error),
      .cycle_cnt    (cycle_cnt),
      .instret_cnt  (instret_cnt)
   );

   always #5 clk = ~clk;

   // Bench cycle count since reset release
   always @(posedge clk) cyc <= rst ? 64'd0 : cyc + 64'd1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      exu_is_mem        = 1'b0;
      exu_redirect      = 1'b0;
      exu_next_pc       = 64'd0;
      exu_rd_wen        = 1'b0;
      a0_value          = 64'd5;
      bus.if_req_ready  = 1'b0;
      bus.if_rsp_valid  = 1'b0;
      bus.if_rsp_inst   = 32'd0;
      bus.if_rsp_err    = 1'b0;
      bus.lsu_req_ready = 1'b0;
      bus.lsu_rsp_valid = 1'b0;
      bus.lsu_rsp_err   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_pc", pc, RESET_PC);
      check("rst_inst", inst, 64'd0);
      check("rst_if_req_valid", bus.if_req_valid, 1'b0);
      check("rst_lsu_req_valid", bus.lsu_req_valid, 1'b0);
      check("rst_rd_wen", rd_wen, 1'b0);
      check("rst_retire", retire, 1'b0);
      check("rst_flags", {halted, halt_good, error}, 3'b000);
      check("rst_cycle_cnt", cycle_cnt, 64'd0);
      check("rst_instret_cnt", instret_cnt, 64'd0);
      rst = 1'b0;
      addr_q.delete();
      addr_q.push_back(RESET_PC);
      exp_instret = 64'd0;
      have_last   = 1'b0;
   endtask

   // Wait for the fetch request, stall it, accept it; returns at the first F_WAIT negedge
   task automatic accept_fetch(input int stall, output logic [63:0] a);
      int n;
      n = 0;
      bus.if_req_ready = 1'b0;
      #1;
      while (bus.if_req_valid !== 1'b1 && n < 8) begin
         @(negedge clk);
         #1;
         n++;
      end
      a = (addr_q.size() != 0) ? addr_q.pop_front() : 64'hdead_beef;
      check("if_req_valid", bus.if_req_valid, 1'b1);
      for (int i = 0; i < stall; i++) begin
         check("if_req_addr_hold", bus.if_req_addr, a);
         @(negedge clk);
         #1;
         check("if_req_valid_hold", bus.if_req_valid, 1'b1);
      end
      check("if_req_addr", bus.if_req_addr, a);
      check("pc", pc, a);
      bus.if_req_ready = 1'b1;
      @(negedge clk);
      bus.if_req_ready = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] ins, input int stall, input int fdly, output logic [63:0] a);
      accept_fetch(stall, a);
      repeat (fdly) @(negedge clk);
      bus.if_rsp_valid = 1'b1;
      bus.if_rsp_inst  = ins;
      @(negedge clk);
      bus.if_rsp_valid = 1'b0;
      bus.if_rsp_inst  = 32'd0;
   endtask

   task automatic exec_instr(input logic [31:0] ins, input logic mem, input logic redir,
                             input logic [63:0] tgt, input logic wen,
                             input int stall, input int fdly, input int ldly);
      logic [63:0] cur;
      logic [63:0] lat;
      logic        bad;
      fetch(ins, stall, fdly, cur);
      exu_is_mem   = mem;
      exu_redirect = redir;
      exu_next_pc  = tgt;
      exu_rd_wen   = wen;
      #1;
      check("exec_inst", inst, ins);
      check("exec_retire", retire, 1'b0);
      check("exec_rd_wen", rd_wen, 1'b0);
      lat = 64'd4 + 64'(stall) + 64'(fdly);
      if (mem) begin
         @(negedge clk);
         #1;
         check("lsu_req_valid", bus.lsu_req_valid, 1'b1);
         check("mreq_if_idle", bus.if_req_valid, 1'b0);
         bus.lsu_req_ready = 1'b1;
         @(negedge clk);
         bus.lsu_req_ready = 1'b0;
         for (int i = 0; i < ldly; i++) begin
            #1;
            check("mwait_rd_wen", rd_wen, 1'b0);
            check("mwait_req_drop", bus.lsu_req_valid, 1'b0);
            @(negedge clk);
         end
         bus.lsu_rsp_valid = 1'b1;
         @(negedge clk);
         bus.lsu_rsp_valid = 1'b0;
         lat = lat + 64'd2 + 64'(ldly);
      end else begin
         @(negedge clk);
      end
      #1;
      bad = redir && (tgt[1:0] != 2'b00);
      check("wb_inst", inst, ins);
      check("wb_rd_wen", rd_wen, wen && !bad);
      check("wb_retire", retire, !bad);
      check("wb_cycle_cnt", cycle_cnt, cyc);
      if (!bad) begin
         if (have_last) check("latency", cyc - last_cyc, lat);
         last_cyc    = cyc;
         have_last   = 1'b1;
         exp_instret = exp_instret + 64'd1;
         addr_q.push_back(redir ? tgt : cur + 64'd4);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      check("instret_cnt", instret_cnt, exp_instret);
      if (bad) begin
         check("misalign_error", error, 1'b1);
         check("misalign_pc_kept", pc, cur);
         check("misalign_no_req", bus.if_req_valid, 1'b0);
      end
   endtask

   task automatic do_ebreak(input logic [63:0] a0);
      logic [63:0] cur;
      logic [63:0] frozen;
      fetch(EBREAK, 0, 0, cur);
      a0_value = a0;
      #1;
      check("ebreak_retire", retire, 1'b1);
      check("ebreak_rd_wen", rd_wen, 1'b0);
      exp_instret = exp_instret + 64'd1;
      @(negedge clk);
      #1;
      frozen = cyc;
      check("halted", halted, 1'b1);
      check("halt_good", halt_good, (a0 == 64'd0));
      check("halt_instret", instret_cnt, exp_instret);
      check("halt_cycle_cnt", cycle_cnt, frozen);
      bus.if_req_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("halt_no_req", {bus.if_req_valid, bus.lsu_req_valid}, 2'b00);
      check("halt_cycle_frozen", cycle_cnt, frozen);
      check("halt_sticky", {halted, error}, 2'b10);
      bus.if_req_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] a;
      logic [63:0] frozen;
      cyc = 64'd0;
      last_cyc = 64'd0;
      rst = 1'b1;
      clear_inputs();

      // straight-line addi stream, then a stalled request
      do_reset();
      repeat (3) exec_instr(ADDI, 1'b0, 1'b0, 64'd0, 1'b1, 0, 0, 0);
      exec_instr(ADDI, 1'b0, 1'b0, 64'd0, 1'b1, 3, 0, 0);

      // load with slow LSU response, then a store at minimum latency
      exec_instr(LOAD, 1'b1, 1'b0, 64'd0, 1'b1, 0, 0, 5);
      exec_instr(STORE, 1'b1, 1'b0, 64'd0, 1'b0, 0, 0, 0);

      // redirects, PC wrap, and a misaligned target
      exec_instr(JAL, 1'b0, 1'b1, 64'h0000_0000_8000_0100, 1'b1, 0, 0, 0);
      exec_instr(ADDI, 1'b0, 1'b0, 64'd0, 1'b1, 0, 1, 0);
      exec_instr(JAL, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 0, 0, 0);
      exec_instr(ADDI, 1'b0, 1'b0, 64'd0, 1'b1, 0, 0, 0);
      exec_instr(ADDI, 1'b0, 1'b0, 64'd0, 1'b1, 0, 0, 0);
      exec_instr(JAL, 1'b0, 1'b1, 64'h0000_0000_8000_0102, 1'b1, 0, 0, 0);
      frozen = cycle_cnt == cyc ? cyc : cyc;
      check("error_cycle_cnt", cycle_cnt, frozen);
      repeat (3) @(negedge clk);
      #1;
      check("error_cycle_frozen", cycle_cnt, frozen);
      check("error_sticky", {error, halted, bus.if_req_valid}, 3'b100);

      // ebreak halts, good and bad exit codes
      do_reset();
      exec_instr(ADDI, 1'b0, 1'b0, 64'd0, 1'b1, 0, 0, 0);
      do_ebreak(64'd0);
      do_reset();
      do_ebreak(64'd1);

      // fetch timeout
      do_reset();
      accept_fetch(0, a);
      repeat (TIMEOUT) @(negedge clk);
      #1;
      check("timeout_not_yet", error, 1'b0);
      @(negedge clk);
      #1;
      check("timeout_error", error, 1'b1);
      check("timeout_no_req", bus.if_req_valid, 1'b0);

      // reset in F_WAIT, then a late response must be ignored
      do_reset();
      exec_instr(ADDI, 1'b0, 1'b0, 64'd0, 1'b1, 0, 0, 0);
      accept_fetch(0, a);
      check("second_fetch_addr", a, RESET_PC + 64'd4);
      repeat (2) @(negedge clk);
      do_reset();
      bus.if_rsp_valid = 1'b1;
      bus.if_rsp_inst  = LOAD;
      repeat (2) @(negedge clk);
      #1;
      check("late_rsp_inst", inst, 64'd0);
      check("late_rsp_pc", pc, RESET_PC);
      check("late_rsp_req", bus.if_req_valid, 1'b1);
      check("late_rsp_retire", retire, 1'b0);
      bus.if_rsp_valid = 1'b0;
      bus.if_rsp_inst  = 32'd0;
      exec_instr(ADDI, 1'b0, 1'b0, 64'd0, 1'b1, 0, 0, 0);

      // fetch bus error
      accept_fetch(0, a);
      bus.if_rsp_valid = 1'b1;
      bus.if_rsp_err   = 1'b1;
      @(negedge clk);
      bus.if_rsp_valid = 1'b0;
      bus.if_rsp_err   = 1'b0;
      #1;
      check("fetch_err_flags", {error, halted}, 2'b10);
      check("fetch_err_inst", inst, ADDI);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
